// File: rtl/axi_addr_router.sv
// Single-master AXI address router: decodes AR/AW against per-slave base/mask windows, one outstanding read and one write.
// Optional AXI_ADDR_ROUTER_TIMEOUT_EN adds per-path response watchdogs and idle draining of stray R/B beats.
module axi_addr_router #(
    parameter int              TAG     = 1,
    parameter int              NS      = 2,
    parameter logic [NS*32-1:0] S_BASE = {32'hA000_0000, 32'h0000_0000},
    parameter logic [NS*32-1:0] S_MASK = {32'hFFFF_0000, 32'hFFF0_0000},
    parameter int              TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_arvalid,
    output logic              m_arready,
    input  logic [TAG-1:0]    m_arid,
    input  logic [31:0]       m_araddr,
    output logic              m_rvalid,
    input  logic              m_rready,
    output logic [63:0]       m_rdata,
    output logic [TAG-1:0]    m_rid,
    output logic [1:0]        m_rresp,
    output logic              m_rlast,
    input  logic              m_awvalid,
    output logic              m_awready,
    input  logic [TAG-1:0]    m_awid,
    input  logic [31:0]       m_awaddr,
    input  logic              m_wvalid,
    output logic              m_wready,
    output logic              m_bvalid,
    input  logic              m_bready,
    output logic [1:0]        m_bresp,
    output logic [TAG-1:0]    m_bid,
    output logic [NS-1:0]     s_arvalid,
    input  logic [NS-1:0]     s_arready,
    output logic [31:0]       s_araddr,
    output logic [TAG-1:0]    s_arid,
    input  logic [NS-1:0]     s_rvalid,
    output logic [NS-1:0]     s_rready,
    input  logic [NS*64-1:0]  s_rdata,
    input  logic [NS*2-1:0]   s_rresp,
    input  logic [NS-1:0]     s_rlast,
    output logic [NS-1:0]     s_awvalid,
    input  logic [NS-1:0]     s_awready,
    output logic [31:0]       s_awaddr,
    output logic [TAG-1:0]    s_awid,
    output logic [NS-1:0]     s_wvalid,
    input  logic [NS-1:0]     s_wready,
    input  logic [NS-1:0]     s_bvalid,
    output logic [NS-1:0]     s_bready,
    input  logic [NS*2-1:0]   s_bresp
);

    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    if (NS < 1 || NS > 8 || TIMEOUT < 1 || TAG < 1) begin : g_bad_cfg
        $error("axi_addr_router: unsupported parameter set");
    end

`ifdef AXI_ADDR_ROUTER_TIMEOUT_EN
    localparam logic [NS-1:0] IDLE_DRAIN = '1;
`else
    localparam logic [NS-1:0] IDLE_DRAIN = '0;
`endif

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_RESP, W_ERR, W_ERRB} w_state_t;

    r_state_t r_state_q, r_state_d;
    w_state_t w_state_q, w_state_d;

    logic [SW-1:0]  r_sel_q, w_sel_q, ar_sel, aw_sel;
    logic           ar_hit, aw_hit;
    logic [TAG-1:0] r_id_q, w_id_q;
    logic [1:0]     r_err_q, r_err_d, w_err_q, w_err_d;
    logic [NS-1:0]  r_oh, w_oh;
    logic           aw_done_q, w_done_q;
    logic           ar_hs, rd_hs, aw_now, w_now, b_hs;
    logic           r_to, w_to;

    // Lowest index wins: scan downwards so later (lower) hits overwrite.
    always_comb begin
        ar_hit = 1'b0;
        ar_sel = '0;
        aw_hit = 1'b0;
        aw_sel = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((m_araddr & S_MASK[32*i +: 32]) == S_BASE[32*i +: 32]) begin
                ar_hit = 1'b1;
                ar_sel = SW'(i);
            end
            if ((m_awaddr & S_MASK[32*i +: 32]) == S_BASE[32*i +: 32]) begin
                aw_hit = 1'b1;
                aw_sel = SW'(i);
            end
        end
    end

    assign r_oh   = NS'(1) << r_sel_q;
    assign w_oh   = NS'(1) << w_sel_q;
    assign ar_hs  = (r_state_q == R_ADDR) && |(s_arready & r_oh);
    assign rd_hs  = (r_state_q == R_DATA) && |(s_rvalid & r_oh) && m_rready;
    assign aw_now = (w_state_q == W_ADDR) && !aw_done_q && |(s_awready & w_oh);
    assign w_now  = (w_state_q == W_ADDR) && !w_done_q && m_wvalid && |(s_wready & w_oh);
    assign b_hs   = (w_state_q == W_RESP) && |(s_bvalid & w_oh) && m_bready;

`ifdef AXI_ADDR_ROUTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt_q, w_cnt_q;
    logic          r_active, w_active, r_hs, w_hs;

    assign r_active = (r_state_q == R_ADDR) || (r_state_q == R_DATA);
    assign w_active = (w_state_q == W_ADDR) || (w_state_q == W_RESP);
    assign r_hs     = ar_hs || rd_hs;
    assign w_hs     = aw_now || w_now || b_hs;

    // Down-counters reload outside the active states and on any slave handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
            w_cnt_q <= '0;
        end else begin
            if (!r_active || r_hs)
                r_cnt_q <= TO_LOAD;
            else if (r_cnt_q != '0)
                r_cnt_q <= r_cnt_q - CW'(1);
            if (!w_active || w_hs)
                w_cnt_q <= TO_LOAD;
            else if (w_cnt_q != '0)
                w_cnt_q <= w_cnt_q - CW'(1);
        end
    end

    assign r_to = r_active && !r_hs && (r_cnt_q == '0);
    assign w_to = w_active && !w_hs && (w_cnt_q == '0);
`else
    assign r_to = 1'b0;
    assign w_to = 1'b0;
`endif

    always_comb begin
        r_state_d = r_state_q;
        r_err_d   = r_err_q;
        m_arready = 1'b0;
        s_arvalid = '0;
        s_rready  = '0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                m_arready = 1'b1;
                s_rready  = IDLE_DRAIN;
                if (m_arvalid) begin
                    r_err_d   = 2'b11;
                    r_state_d = ar_hit ? R_ADDR : R_ERR;
                end
            end
            R_ADDR: begin
                s_arvalid = r_oh;
                if (ar_hs) begin
                    r_state_d = R_DATA;
                end else if (r_to) begin
                    r_err_d   = 2'b10;
                    r_state_d = R_ERR;
                end
            end
            R_DATA: begin
                m_rvalid = |(s_rvalid & r_oh);
                m_rdata  = s_rdata[int'(r_sel_q)*64 +: 64];
                m_rresp  = s_rresp[int'(r_sel_q)*2 +: 2];
                m_rlast  = |(s_rlast & r_oh);
                s_rready = m_rready ? r_oh : '0;
                if (rd_hs && m_rlast) begin
                    r_state_d = R_IDLE;
                end else if (r_to) begin
                    r_err_d   = 2'b10;
                    r_state_d = R_ERR;
                end
            end
            R_ERR: begin
                m_rvalid = 1'b1;
                m_rresp  = r_err_q;
                m_rlast  = 1'b1;
                if (m_rready)
                    r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rst) begin
            m_arready = 1'b0;
            s_arvalid = '0;
            s_rready  = '0;
            m_rvalid  = 1'b0;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_err_d   = w_err_q;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        unique case (w_state_q)
            W_IDLE: begin
                m_awready = 1'b1;
                s_bready  = IDLE_DRAIN;
                if (m_awvalid) begin
                    w_err_d   = 2'b11;
                    w_state_d = aw_hit ? W_ADDR : W_ERR;
                end
            end
            W_ADDR: begin
                s_awvalid = aw_done_q ? '0 : w_oh;
                s_wvalid  = (w_done_q || !m_wvalid) ? '0 : w_oh;
                m_wready  = !w_done_q && |(s_wready & w_oh);
                if ((aw_done_q || aw_now) && (w_done_q || w_now)) begin
                    w_state_d = W_RESP;
                end else if (w_to) begin
                    w_err_d   = 2'b10;
                    w_state_d = (w_done_q || w_now) ? W_ERRB : W_ERR;
                end
            end
            W_RESP: begin
                m_bvalid = |(s_bvalid & w_oh);
                m_bresp  = s_bresp[int'(w_sel_q)*2 +: 2];
                s_bready = m_bready ? w_oh : '0;
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end else if (w_to) begin
                    w_err_d   = 2'b10;
                    w_state_d = W_ERRB;
                end
            end
            W_ERR: begin
                m_wready = 1'b1;
                if (m_wvalid)
                    w_state_d = W_ERRB;
            end
            W_ERRB: begin
                m_bvalid = 1'b1;
                m_bresp  = w_err_q;
                if (m_bready)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        if (rst) begin
            m_awready = 1'b0;
            m_wready  = 1'b0;
            m_bvalid  = 1'b0;
            s_awvalid = '0;
            s_wvalid  = '0;
            s_bready  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_sel_q   <= '0;
            r_id_q    <= '0;
            r_err_q   <= 2'b00;
            s_araddr  <= '0;
            w_state_q <= W_IDLE;
            w_sel_q   <= '0;
            w_id_q    <= '0;
            w_err_q   <= 2'b00;
            s_awaddr  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_err_q   <= r_err_d;
            w_state_q <= w_state_d;
            w_err_q   <= w_err_d;
            if (r_state_q == R_IDLE && m_arvalid) begin
                r_sel_q  <= ar_sel;
                r_id_q   <= m_arid;
                s_araddr <= m_araddr;
            end
            if (w_state_q == W_IDLE && m_awvalid) begin
                w_sel_q  <= aw_sel;
                w_id_q   <= m_awid;
                s_awaddr <= m_awaddr;
            end
            // Flags only live while the AW/W pair is being collected.
            aw_done_q <= (w_state_d == W_ADDR) && (aw_done_q || aw_now);
            w_done_q  <= (w_state_d == W_ADDR) && (w_done_q || w_now);
        end
    end

    assign s_arid = r_id_q;
    assign m_rid  = r_id_q;
    assign s_awid = w_id_q;
    assign m_bid  = w_id_q;

endmodule

// File: tb/tb_axi_addr_router.sv
// Directed bench for axi_addr_router: decode hits/misses, burst pass-through, concurrent paths, stall/timeout and reset.
module tb_axi_addr_router;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [0:0]   m_arid, m_rid, m_awid, m_bid, s_arid, s_awid;
    logic [31:0]  m_araddr, m_awaddr, s_araddr, s_awaddr;
    logic [63:0]  m_rdata;
    logic [1:0]   m_rresp, m_bresp;
    logic         m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]   s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [1:0]   s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [127:0] s_rdata;
    logic [3:0]   s_rresp, s_bresp;

    int total = 0;
    int bad   = 0;

`ifdef AXI_ADDR_ROUTER_TIMEOUT_EN
    localparam logic [1:0] DRAIN = 2'b11;
`else
    localparam logic [1:0] DRAIN = 2'b00;
`endif

    axi_addr_router #(.TAG(1), .NS(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m_arvalid = 0; m_arid = 0; m_araddr = 0; m_rready = 0;
        m_awvalid = 0; m_awid = 0; m_awaddr = 0; m_wvalid = 0; m_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        tick(); tick();
        #1;
        chk("rst_arready", m_arready, 1'b0);
        chk("rst_awready", m_awready, 1'b0);
        chk("rst_s_rready", s_rready, 2'b00);
        rst = 1'b0;
        #1;
        chk("idle_arready", m_arready, 1'b1);
        chk("idle_awready", m_awready, 1'b1);
        chk("idle_s_rready", s_rready, DRAIN);
        chk("idle_s_bready", s_bready, DRAIN);

        // read hit on slave0
        tick();
        m_arvalid = 1; m_araddr = 32'h0000_1000; m_arid = 1'b1;
        tick();
        m_arvalid = 0;
        #1;
        chk("rd_s_arvalid", s_arvalid, 2'b01);
        chk("rd_s_araddr", s_araddr, 32'h0000_1000);
        chk("rd_s_arid", s_arid, 1'b1);
        chk("rd_arready_busy", m_arready, 1'b0);
        s_arready = 2'b01;
        tick();
        s_arready = 2'b00;
        s_rvalid = 2'b01; s_rlast = 2'b01; s_rresp = 4'b1100;
        s_rdata = {64'hDEAD_BEEF_0000_0001, 64'h1122_3344_5566_7788};
        m_rready = 1;
        #1;
        chk("rd_m_rvalid", m_rvalid, 1'b1);
        chk("rd_m_rdata", m_rdata, 64'h1122_3344_5566_7788);
        chk("rd_m_rresp", m_rresp, 2'b00);
        chk("rd_m_rid", m_rid, 1'b1);
        chk("rd_m_rlast", m_rlast, 1'b1);
        chk("rd_s_rready", s_rready, 2'b01);
        chk("rd_s_arvalid_off", s_arvalid, 2'b00);
        tick();
        s_rvalid = 0; s_rlast = 0;
        #1;
        chk("rd_done_rvalid", m_rvalid, 1'b0);
        chk("rd_done_arready", m_arready, 1'b1);

        // write hit on slave1, W accepted before AW
        m_awvalid = 1; m_awaddr = 32'hA000_0010; m_awid = 1'b0; m_wvalid = 1;
        #1;
        chk("wr_idle_wready", m_wready, 1'b0);
        tick();
        m_awvalid = 0; s_wready = 2'b10;
        #1;
        chk("wr_s_awvalid", s_awvalid, 2'b10);
        chk("wr_s_wvalid", s_wvalid, 2'b10);
        chk("wr_m_wready", m_wready, 1'b1);
        chk("wr_s_awaddr", s_awaddr, 32'hA000_0010);
        tick();
        m_wvalid = 0; s_wready = 0; s_awready = 2'b10;
        #1;
        chk("wr_w_held_off", s_wvalid, 2'b00);
        chk("wr_s_awvalid2", s_awvalid, 2'b10);
        tick();
        s_awready = 0; s_bvalid = 2'b10; s_bresp = 4'b0001; m_bready = 1;
        #1;
        chk("wr_m_bvalid", m_bvalid, 1'b1);
        chk("wr_m_bresp", m_bresp, 2'b00);
        chk("wr_m_bid", m_bid, 1'b0);
        chk("wr_s_bready", s_bready, 2'b10);
        tick();
        s_bvalid = 0;
        #1;
        chk("wr_done_awready", m_awready, 1'b1);

        // read miss then write miss
        m_arvalid = 1; m_araddr = 32'h5000_0000; m_arid = 1'b1; m_rready = 0;
        tick();
        m_arvalid = 0;
        #1;
        chk("rmiss_s_arvalid", s_arvalid, 2'b00);
        chk("rmiss_rvalid", m_rvalid, 1'b1);
        chk("rmiss_rresp", m_rresp, 2'b11);
        chk("rmiss_rlast", m_rlast, 1'b1);
        chk("rmiss_rdata", m_rdata, 64'h0);
        chk("rmiss_rid", m_rid, 1'b1);
        tick();
        chk("rmiss_hold", m_rvalid, 1'b1);
        m_rready = 1;
        tick();
        chk("rmiss_done", m_rvalid, 1'b0);
        m_awvalid = 1; m_awaddr = 32'hF000_0000; m_awid = 1'b1;
        tick();
        m_awvalid = 0;
        #1;
        chk("wmiss_wready", m_wready, 1'b1);
        chk("wmiss_s_awvalid", s_awvalid, 2'b00);
        chk("wmiss_bvalid_early", m_bvalid, 1'b0);
        m_wvalid = 1;
        tick();
        m_wvalid = 0;
        #1;
        chk("wmiss_s_wvalid", s_wvalid, 2'b00);
        chk("wmiss_bvalid", m_bvalid, 1'b1);
        chk("wmiss_bresp", m_bresp, 2'b11);
        chk("wmiss_bid", m_bid, 1'b1);
        tick();
        chk("wmiss_done", m_bvalid, 1'b0);

        // concurrent read (slave0, 4-beat burst) and write (slave1)
        m_arvalid = 1; m_araddr = 32'h0000_2000; m_arid = 1'b0;
        m_awvalid = 1; m_awaddr = 32'hA000_0100; m_awid = 1'b1; m_wvalid = 1;
        tick();
        m_arvalid = 0; m_awvalid = 0;
        s_arready = 2'b01; s_awready = 2'b10; s_wready = 2'b10;
        #1;
        chk("cc_s_arvalid", s_arvalid, 2'b01);
        chk("cc_s_awvalid", s_awvalid, 2'b10);
        chk("cc_s_wvalid", s_wvalid, 2'b10);
        tick();
        s_arready = 0; s_awready = 0; s_wready = 0; m_wvalid = 0;
        s_bvalid = 2'b10; s_bresp = 4'b0100; s_rresp = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            s_rvalid = 2'b01;
            s_rlast  = (k == 3) ? 2'b01 : 2'b00;
            s_rdata  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h100 + 64'(k)};
            #1;
            chk("cc_beat_valid", m_rvalid, 1'b1);
            chk("cc_beat_data", m_rdata, 64'h100 + 64'(k));
            chk("cc_beat_last", m_rlast, (k == 3) ? 1'b1 : 1'b0);
            if (k == 0) begin
                chk("cc_bvalid", m_bvalid, 1'b1);
                chk("cc_bresp", m_bresp, 2'b01);
                chk("cc_bid", m_bid, 1'b1);
            end
            tick();
            s_bvalid = 0;
        end
        s_rvalid = 0; s_rlast = 0;
        #1;
        chk("cc_r_idle", m_arready, 1'b1);
        chk("cc_w_idle", m_awready, 1'b1);

        // slave0 never accepts AR
        m_rready = 0;
        m_arvalid = 1; m_araddr = 32'h0000_0040; m_arid = 1'b0;
        tick();
        m_arvalid = 0;
        repeat (7) tick();
        chk("to_pre_rvalid", m_rvalid, 1'b0);
        chk("to_pre_arvalid", s_arvalid, 2'b01);
        tick();
`ifdef AXI_ADDR_ROUTER_TIMEOUT_EN
        chk("to_rvalid", m_rvalid, 1'b1);
        chk("to_rresp", m_rresp, 2'b10);
        chk("to_rlast", m_rlast, 1'b1);
        m_rready = 1;
        tick();
        m_rready = 0;
`else
        chk("stall_rvalid", m_rvalid, 1'b0);
        chk("stall_arvalid", s_arvalid, 2'b01);
        rst = 1;
        tick();
        rst = 0;
`endif
        #1;
        chk("to_back_idle", m_arready, 1'b1);

        // reset while in R_DATA
        m_arvalid = 1; m_araddr = 32'h0000_3000; m_arid = 1'b1;
        tick();
        m_arvalid = 0; s_arready = 2'b01;
        tick();
        s_arready = 0; s_rvalid = 2'b01; m_rready = 1;
        #1;
        chk("rd2_rvalid", m_rvalid, 1'b1);
        rst = 1;
        #1;
        chk("rstmid_rvalid", m_rvalid, 1'b0);
        chk("rstmid_s_rready", s_rready, 2'b00);
        chk("rstmid_arready", m_arready, 1'b0);
        tick();
        rst = 0;
        #1;
        chk("post_rst_arready", m_arready, 1'b1);
        chk("post_rst_rvalid", m_rvalid, 1'b0);
        chk("post_rst_arvalid", s_arvalid, 2'b00);
        chk("post_rst_araddr", s_araddr, 32'h0);
        s_rvalid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
